// File: rtl/mem_access_stage.sv
// MEM-stage datapath and control between the EX/MEM and MEM/WB latches.
// Issues loads and stores to a handshaked data memory. Stores are steered onto
// byte lanes, and load data is lane-selected and extended. The block flags
// misaligned accesses and memory timeouts. While an access is outstanding it
// stalls the upstream stages and shows a bubble (reg_write_out=0) to MEM/WB.
module mem_access_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] write_data_in,
    input  logic [4:0]  write_register_in,
    input  logic        reg_write_in,
    input  logic        mem_to_reg_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [1:0]  mem_size_in,
    input  logic        mem_unsigned_in,
    input  logic [31:0] pc_plus_4_in,
    input  logic        is_jal_in,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    output logic        stall_out,
    output logic [31:0] alu_result_out,
    output logic [31:0] read_data_out,
    output logic [4:0]  write_register_out,
    output logic        reg_write_out,
    output logic        mem_to_reg_out,
    output logic [31:0] pc_plus_4_out,
    output logic        is_jal_out,
    output logic        misalign_err,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Last wait cycle index. The counter starts at 0 in the first REQ cycle.
    localparam logic [9:0] TMO_LAST = 10'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [9:0]  cnt_q, cnt_d;
    logic [31:0] load_q, load_d;
    logic        bus_err_q, bus_err_d;
    logic [1:0]  lo_q, lo_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;

    logic        mem_op_s;
    logic        misaligned_s;
    logic        access_s;
    logic        stall_s;
    logic        reg_write_s;
    logic [31:0] read_data_s;
    logic        misalign_s;

    // Halfwords need an even address. Words (size 10 or 11) need a 4-byte aligned address.
    function automatic logic addr_misaligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'b00:   addr_misaligned = 1'b0;
            2'b01:   addr_misaligned = lo[0];
            default: addr_misaligned = (lo != 2'b00);
        endcase
    endfunction

    // Byte enables for a store of the given size at the given byte offset.
    function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'b00:   store_be = 4'b0001 << lo;
            2'b01:   store_be = lo[1] ? 4'b1100 : 4'b0011;
            default: store_be = 4'b1111;
        endcase
    endfunction

    // Store data is replicated on every lane, so the byte enables alone pick the target lane.
    function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] wd);
        case (size)
            2'b00:   store_wdata = {4{wd[7:0]}};
            2'b01:   store_wdata = {2{wd[15:0]}};
            default: store_wdata = wd;
        endcase
    endfunction

    // Select the addressed lane of the read word, then sign- or zero-extend it.
    function automatic logic [31:0] load_format(input logic [1:0] size, input logic [1:0] lo,
                                                input logic uns, input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        case (lo)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = lo[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            2'b00:   load_format = uns ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   load_format = uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: load_format = rdata;
        endcase
    endfunction

    assign mem_op_s     = valid_in & (mem_read_in | mem_write_in);
    assign misaligned_s = mem_op_s & addr_misaligned(mem_size_in, alu_result_in[1:0]);
    assign access_s     = mem_op_s & ~misaligned_s;

    // Next-state logic for the access FSM and its request and capture registers.
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        cnt_d     = cnt_q;
        load_d    = load_q;
        bus_err_d = bus_err_q;
        lo_d      = lo_q;
        size_d    = size_q;
        uns_d     = uns_q;
        case (state_q)
            ST_IDLE: begin
                if (access_s) begin
                    state_d = ST_REQ;
                    req_d   = 1'b1;
                    we_d    = mem_write_in;
                    addr_d  = {alu_result_in[31:2], 2'b00};
                    wdata_d = store_wdata(mem_size_in, write_data_in);
                    be_d    = store_be(mem_size_in, alu_result_in[1:0]);
                    cnt_d   = 10'd0;
                    lo_d    = alu_result_in[1:0];
                    size_d  = mem_size_in;
                    uns_d   = mem_unsigned_in;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (dmem_ack) begin
                    state_d = ST_DONE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    load_d  = we_q ? 32'd0 : load_format(size_q, lo_q, uns_q, dmem_rdata);
                end else if (cnt_q == TMO_LAST) begin
                    state_d   = ST_DONE;
                    req_d     = 1'b0;
                    we_d      = 1'b0;
                    load_d    = 32'd0;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            ST_DONE: begin
                state_d   = ST_IDLE;
                bus_err_d = 1'b0;
            end
            default: begin
                state_d   = ST_IDLE;
                req_d     = 1'b0;
                we_d      = 1'b0;
                bus_err_d = 1'b0;
            end
        endcase
    end

    // State and request registers. Reset drops any in-flight request immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            be_q      <= 4'd0;
            cnt_q     <= 10'd0;
            load_q    <= 32'd0;
            bus_err_q <= 1'b0;
            lo_q      <= 2'd0;
            size_q    <= 2'd0;
            uns_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            cnt_q     <= cnt_d;
            load_q    <= load_d;
            bus_err_q <= bus_err_d;
            lo_q      <= lo_d;
            size_q    <= size_d;
            uns_q     <= uns_d;
        end
    end

    // Stall, write-enable gating and load-data selection for each FSM state.
    always_comb begin
        stall_s     = 1'b0;
        reg_write_s = 1'b0;
        read_data_s = 32'd0;
        misalign_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                stall_s     = access_s;
                reg_write_s = reg_write_in & valid_in & ~misaligned_s & ~access_s;
                misalign_s  = misaligned_s;
            end
            ST_REQ: begin
                stall_s     = 1'b1;
                reg_write_s = 1'b0;
            end
            ST_DONE: begin
                stall_s     = 1'b0;
                reg_write_s = reg_write_in & ~bus_err_q;
                read_data_s = load_q;
            end
            default: begin
                stall_s     = 1'b0;
                reg_write_s = 1'b0;
            end
        endcase
    end

    assign stall_out          = stall_s & reset;
    assign reg_write_out      = reg_write_s & reset;
    assign read_data_out      = read_data_s;
    assign misalign_err       = misalign_s;
    assign bus_err            = bus_err_q;

    assign dmem_req           = req_q;
    assign dmem_we            = we_q;
    assign dmem_addr          = addr_q;
    assign dmem_wdata         = wdata_q;
    assign dmem_be            = be_q;

    assign alu_result_out     = alu_result_in;
    assign write_register_out = write_register_in;
    assign mem_to_reg_out     = mem_to_reg_in;
    assign pc_plus_4_out      = pc_plus_4_in;
    assign is_jal_out         = is_jal_in;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage. It uses directed cases plus randomized loads, stores
// and passthrough ops. A simple memory responder acks after a chosen number of
// REQ cycles, and arithmetic reference functions give the expected values.
module tb_mem_access_stage;

    localparam int TMO = 6;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic [31:0] alu_result_in;
    logic [31:0] write_data_in;
    logic [4:0]  write_register_in;
    logic        reg_write_in;
    logic        mem_to_reg_in;
    logic        mem_read_in;
    logic        mem_write_in;
    logic [1:0]  mem_size_in;
    logic        mem_unsigned_in;
    logic [31:0] pc_plus_4_in;
    logic        is_jal_in;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        stall_out;
    logic [31:0] alu_result_out;
    logic [31:0] read_data_out;
    logic [4:0]  write_register_out;
    logic        reg_write_out;
    logic        mem_to_reg_out;
    logic [31:0] pc_plus_4_out;
    logic        is_jal_out;
    logic        misalign_err;
    logic        bus_err;

    int vectors = 0;
    int miscompares = 0;

    mem_access_stage #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .alu_result_in(alu_result_in),
        .write_data_in(write_data_in), .write_register_in(write_register_in),
        .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .mem_size_in(mem_size_in),
        .mem_unsigned_in(mem_unsigned_in), .pc_plus_4_in(pc_plus_4_in), .is_jal_in(is_jal_in),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .stall_out(stall_out), .alu_result_out(alu_result_out), .read_data_out(read_data_out),
        .write_register_out(write_register_out), .reg_write_out(reg_write_out),
        .mem_to_reg_out(mem_to_reg_out), .pc_plus_4_out(pc_plus_4_out),
        .is_jal_out(is_jal_out), .misalign_err(misalign_err), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit m_misaligned(input logic [1:0] size, input logic [31:0] addr);
        return (int'(addr % 32'd4) % nbytes(size)) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] size, input logic [31:0] addr);
        int off;
        int mask;
        off  = int'(addr % 32'd4);
        mask = ((1 << nbytes(size)) - 1) << off;
        return 4'(mask);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] wd);
        if (nbytes(size) == 1) return {24'd0, wd[7:0]} * 32'h0101_0101;
        if (nbytes(size) == 2) return {16'd0, wd[15:0]} * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] size, input logic uns,
                                           input logic [31:0] addr, input logic [31:0] rdata);
        int bytes;
        int off;
        logic [31:0] val;
        logic [31:0] mask;
        bytes = nbytes(size);
        if (bytes == 4) return rdata;
        off  = int'(addr % 32'd4);
        val  = rdata >> (8 * off);
        mask = (32'd1 << (8 * bytes)) - 32'd1;
        val  = val & mask;
        if (!uns && val >= (32'd1 << (8 * bytes - 1))) val = val | ~mask;
        return val;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_nop();
        @(negedge clk);
        valid_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0;
        reg_write_in = 1'b0; dmem_ack = 1'b0;
        #1;
        chk("idle stall", {31'd0, stall_out}, 32'd0);
        chk("idle req", {31'd0, dmem_req}, 32'd0);
        chk("idle bus_err", {31'd0, bus_err}, 32'd0);
    endtask

    // Non-memory instruction (or invalid memory op): zero-latency passthrough.
    task automatic pass_op(input logic [31:0] alu, input logic v, input logic rw);
        logic [31:0] pc;
        logic [4:0]  wr;
        logic        jal;
        logic        mtr;
        pc  = $urandom;
        wr  = 5'($urandom_range(0, 31));
        jal = 1'($urandom_range(0, 1));
        mtr = 1'($urandom_range(0, 1));
        @(negedge clk);
        valid_in = v; alu_result_in = alu; write_data_in = $urandom;
        write_register_in = wr; reg_write_in = rw; mem_to_reg_in = mtr;
        mem_read_in = v ? 1'b0 : 1'($urandom_range(0, 1));
        mem_write_in = 1'b0; mem_size_in = 2'($urandom_range(0, 3));
        mem_unsigned_in = 1'b0; pc_plus_4_in = pc; is_jal_in = jal;
        #1;
        chk("pass alu", alu_result_out, alu);
        chk("pass wreg", {27'd0, write_register_out}, {27'd0, wr});
        chk("pass pc4", pc_plus_4_out, pc);
        chk("pass jal", {31'd0, is_jal_out}, {31'd0, jal});
        chk("pass m2r", {31'd0, mem_to_reg_out}, {31'd0, mtr});
        chk("pass regwr", {31'd0, reg_write_out}, {31'd0, rw & v});
        chk("pass rdata", read_data_out, 32'd0);
        chk("pass stall", {31'd0, stall_out}, 32'd0);
        chk("pass misalign", {31'd0, misalign_err}, 32'd0);
        @(negedge clk); #1;
        chk("pass no req", {31'd0, dmem_req}, 32'd0);
    endtask

    // Load or store. lat = REQ cycle in which ack arrives (1 = zero-wait);
    // lat of 0 or above TMO means the memory never answers.
    task automatic mem_op(input string tag, input logic is_load, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [1:0] size, input logic uns,
                          input logic rw, input int lat, input logic [31:0] rdata,
                          input logic [31:0] exp_rd);
        logic [31:0] pc;
        logic [4:0]  wr;
        int          stalls;
        int          n_req;
        bit          tmo;
        pc = $urandom;
        wr = 5'($urandom_range(0, 31));
        @(negedge clk);
        valid_in = 1'b1; alu_result_in = addr; write_data_in = wd; write_register_in = wr;
        reg_write_in = rw; mem_to_reg_in = is_load; mem_read_in = is_load;
        mem_write_in = ~is_load; mem_size_in = size; mem_unsigned_in = uns;
        pc_plus_4_in = pc; is_jal_in = 1'b0; dmem_ack = 1'b0;
        #1;
        if (m_misaligned(size, addr)) begin
            chk({tag, " misalign_err"}, {31'd0, misalign_err}, 32'd1);
            chk({tag, " mis stall"}, {31'd0, stall_out}, 32'd0);
            chk({tag, " mis regwr"}, {31'd0, reg_write_out}, 32'd0);
            @(negedge clk); #1;
            chk({tag, " mis no req"}, {31'd0, dmem_req}, 32'd0);
            drive_nop();
        end else begin
            chk({tag, " misalign_err"}, {31'd0, misalign_err}, 32'd0);
            chk({tag, " issue regwr"}, {31'd0, reg_write_out}, 32'd0);
            stalls = stall_out ? 1 : 0;
            tmo    = (lat < 1) || (lat > TMO);
            n_req  = tmo ? TMO : lat;
            for (int i = 1; i <= n_req; i++) begin
                @(negedge clk);
                if (i == lat) begin
                    dmem_ack = 1'b1; dmem_rdata = rdata;
                end else begin
                    dmem_ack = 1'b0; dmem_rdata = $urandom;
                end
                #1;
                if (stall_out) stalls++;
                chk({tag, " req held"}, {31'd0, dmem_req}, 32'd1);
                if (i == 1) begin
                    chk({tag, " we"}, {31'd0, dmem_we}, {31'd0, ~is_load});
                    chk({tag, " addr"}, dmem_addr, addr & 32'hFFFF_FFFC);
                    chk({tag, " be"}, {28'd0, dmem_be}, {28'd0, m_be(size, addr)});
                    if (!is_load) chk({tag, " wdata"}, dmem_wdata, m_wdata(size, wd));
                end
            end
            @(negedge clk);
            dmem_ack = 1'b0;
            #1;
            chk({tag, " stall cycles"}, 32'(stalls), 32'(n_req + 1));
            chk({tag, " done stall"}, {31'd0, stall_out}, 32'd0);
            chk({tag, " done req"}, {31'd0, dmem_req}, 32'd0);
            chk({tag, " bus_err"}, {31'd0, bus_err}, {31'd0, tmo});
            chk({tag, " done regwr"}, {31'd0, reg_write_out}, {31'd0, rw & ~tmo});
            chk({tag, " done alu"}, alu_result_out, addr);
            chk({tag, " done wreg"}, {27'd0, write_register_out}, {27'd0, wr});
            chk({tag, " done pc4"}, pc_plus_4_out, pc);
            if (is_load && !tmo) chk({tag, " rdata"}, read_data_out, exp_rd);
            drive_nop();
        end
    endtask

    initial begin
        logic        ld;
        logic [1:0]  sz;
        logic        un;
        logic [31:0] ad;
        logic [31:0] rd;
        int          lt;

        // Reset asserted with a live instruction on the inputs.
        reset = 1'b0; valid_in = 1'b1; alu_result_in = 32'h0000_0040; write_data_in = 32'd0;
        write_register_in = 5'd3; reg_write_in = 1'b1; mem_to_reg_in = 1'b0;
        mem_read_in = 1'b0; mem_write_in = 1'b0; mem_size_in = 2'd2; mem_unsigned_in = 1'b0;
        pc_plus_4_in = 32'd4; is_jal_in = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'd0;
        #1;
        chk("rst req", {31'd0, dmem_req}, 32'd0);
        chk("rst stall", {31'd0, stall_out}, 32'd0);
        chk("rst regwr", {31'd0, reg_write_out}, 32'd0);
        chk("rst be", {28'd0, dmem_be}, 32'd0);
        chk("rst bus_err", {31'd0, bus_err}, 32'd0);
        @(negedge clk);
        reset = 1'b1; valid_in = 1'b0; reg_write_in = 1'b0;

        // Directed cases.
        pass_op(32'h1234_5679, 1'b1, 1'b1);   // ADD with odd result is not a memory access
        mem_op("LW0", 1'b1, 32'h100, 32'd0, 2'd2, 1'b0, 1'b1, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        mem_op("LB", 1'b1, 32'h103, 32'd0, 2'd0, 1'b0, 1'b1, 1, 32'h80AA_55CC, 32'hFFFF_FF80);
        mem_op("LBU", 1'b1, 32'h103, 32'd0, 2'd0, 1'b1, 1'b1, 2, 32'h80AA_55CC, 32'h0000_0080);
        mem_op("SB", 1'b0, 32'h102, 32'h1234_5678, 2'd0, 1'b0, 1'b0, 1, 32'd0, 32'd0);
        mem_op("LH5", 1'b1, 32'h202, 32'd0, 2'd1, 1'b0, 1'b1, 5, 32'h8001_1234, 32'hFFFF_8001);
        mem_op("TMO", 1'b1, 32'h204, 32'd0, 2'd2, 1'b0, 1'b1, 0, 32'd0, 32'd0);
        mem_op("LWMIS", 1'b1, 32'h101, 32'd0, 2'd2, 1'b0, 1'b1, 1, 32'd0, 32'd0);
        mem_op("SWTMO", 1'b0, 32'h300, 32'hCAFE_F00D, 2'd3, 1'b0, 1'b0, TMO + 1, 32'd0, 32'd0);

        // Reset in the middle of a pending request; a late ack must be ignored.
        @(negedge clk);
        valid_in = 1'b1; alu_result_in = 32'h400; mem_read_in = 1'b1; mem_write_in = 1'b0;
        mem_size_in = 2'd2; reg_write_in = 1'b1; dmem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        chk("mid req up", {31'd0, dmem_req}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("mid req drop", {31'd0, dmem_req}, 32'd0);
        chk("mid stall", {31'd0, stall_out}, 32'd0);
        chk("mid regwr", {31'd0, reg_write_out}, 32'd0);
        @(negedge clk);
        dmem_ack = 1'b1; dmem_rdata = 32'h5555_AAAA;
        valid_in = 1'b0; mem_read_in = 1'b0; reg_write_in = 1'b0;
        reset = 1'b1;
        @(negedge clk); #1;
        chk("post req", {31'd0, dmem_req}, 32'd0);
        chk("post we", {31'd0, dmem_we}, 32'd0);
        chk("post addr", dmem_addr, 32'd0);
        chk("post wdata", dmem_wdata, 32'd0);
        chk("post be", {28'd0, dmem_be}, 32'd0);
        chk("post bus_err", {31'd0, bus_err}, 32'd0);
        chk("post stall", {31'd0, stall_out}, 32'd0);
        chk("post rdata", read_data_out, 32'd0);
        dmem_ack = 1'b0;

        // Randomized mix of loads, stores and passthrough ops.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                pass_op($urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end else begin
                ld = 1'($urandom_range(0, 1));
                sz = 2'($urandom_range(0, 3));
                un = 1'($urandom_range(0, 1));
                ad = $urandom;
                if ($urandom_range(0, 1) == 1) ad = ad & ~(32'(nbytes(sz)) - 32'd1);
                lt = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, TMO));
                rd = $urandom;
                mem_op("RND", ld, ad, $urandom, sz, un, 1'($urandom_range(0, 1)), lt, rd,
                       m_load(sz, un, ad, rd));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
